rf_commit_sequencer: RTL and testbench

- Sits between the reorder buffer and the register file. It is the only driver of the register file's commit/rollback write port.
- Buffers commit requests from the ROB in a small FIFO and issues at most one register-file write per cycle.
- Sequences rollback: drains pending commits, issues a single-cycle rollback strobe, waits a recovery window, then acknowledges the ROB.

---
 rtl/rf_commit_sequencer.sv | 146 ++++++++++++++
 tb/tb_rf_commit_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_commit_sequencer.sv
// Commit/rollback write-port sequencer between the ROB and the register file.
// Define COMMIT_BYPASS_EN to let a commit into an empty FIFO skip the FIFO (latency 1).
module rf_commit_sequencer #(
  parameter int DEPTH          = 4,
  parameter int DEPTH_LOG      = 2,
  parameter int TAG_W          = 5,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 commit_valid_from_rob,
  output logic                 commit_ready_to_rob,
  input  logic [4:0]           commit_rd_from_rob,
  input  logic [TAG_W-1:0]     commit_Q_from_rob,
  input  logic [31:0]          commit_V_from_rob,
  input  logic                 rollback_req_from_rob,
  output logic                 rollback_done_to_rob,
  output logic                 commit_flag_to_regfile,
  output logic                 rollback_flag_to_regfile,
  output logic [4:0]           rd_to_regfile,
  output logic [TAG_W-1:0]     Q_to_regfile,
  output logic [31:0]          V_to_regfile,
  output logic [DEPTH_LOG:0]   pending_cnt
);

  localparam int ENTRY_W = 5 + TAG_W + 32;
  localparam int RC_W    = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [DEPTH_LOG:0] DEPTH_V   = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [RC_W-1:0]    RC_START  = RC_W'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    FLUSH   = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e                 state_q;
  logic [DEPTH_LOG-1:0]   head_q, tail_q;
  logic [DEPTH_LOG:0]     cnt_q, cnt_d;
  logic [RC_W-1:0]        recov_q;
  logic [ENTRY_W-1:0]     mem_q [DEPTH];

  logic                   commit_flag_q, rollback_flag_q, done_q;
  logic [4:0]             rd_q;
  logic [TAG_W-1:0]       Q_q;
  logic [31:0]            V_q;

  logic                   accept, push, pop, bypass;
  logic [ENTRY_W-1:0]     in_entry, head_entry;
  logic [4:0]             head_rd, in_rd;

  assign commit_ready_to_rob = (state_q == IDLE) && (cnt_q < DEPTH_V);
  assign accept     = commit_valid_from_rob && commit_ready_to_rob;
  assign in_entry   = {commit_rd_from_rob, commit_Q_from_rob, commit_V_from_rob};
  assign in_rd      = commit_rd_from_rob;
  assign head_entry = mem_q[head_q];
  assign head_rd    = head_entry[ENTRY_W-1 -: 5];

`ifdef COMMIT_BYPASS_EN
  assign bypass = accept && (cnt_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;
  assign pop  = ((state_q == IDLE) || (state_q == DRAIN)) && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Entry storage carries no reset: the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (rdy_in && push) mem_q[tail_q] <= in_entry;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      head_q          <= '0;
      tail_q          <= '0;
      cnt_q           <= '0;
      recov_q         <= '0;
      commit_flag_q   <= 1'b0;
      rollback_flag_q <= 1'b0;
      done_q          <= 1'b0;
      rd_q            <= '0;
      Q_q             <= '0;
      V_q             <= '0;
    end else if (rdy_in) begin
      cnt_q           <= cnt_d;
      commit_flag_q   <= 1'b0;
      rollback_flag_q <= 1'b0;
      done_q          <= 1'b0;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;

      // Writes to x0 are consumed silently; the last real write stays on the bus.
      if (pop) begin
        commit_flag_q <= (head_rd != 5'd0);
        if (head_rd != 5'd0) {rd_q, Q_q, V_q} <= head_entry;
      end else if (bypass) begin
        commit_flag_q <= (in_rd != 5'd0);
        if (in_rd != 5'd0) {rd_q, Q_q, V_q} <= in_entry;
      end

      case (state_q)
        IDLE: begin
          if (rollback_req_from_rob) state_q <= DRAIN;
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q         <= FLUSH;
            rollback_flag_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q <= RECOVER;
          recov_q <= RC_START;
        end
        RECOVER: begin
          if (recov_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            recov_q <= recov_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign commit_flag_to_regfile   = commit_flag_q;
  assign rollback_flag_to_regfile = rollback_flag_q;
  assign rollback_done_to_rob     = done_q;
  assign rd_to_regfile            = rd_q;
  assign Q_to_regfile             = Q_q;
  assign V_to_regfile             = V_q;
  assign pending_cnt              = cnt_q;

endmodule

// File: tb/tb_rf_commit_sequencer.sv
// Directed, table-driven bench for rf_commit_sequencer (default build, FIFO latency 2).
module tb_rf_commit_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        commit_valid_from_rob;
  logic        commit_ready_to_rob;
  logic [4:0]  commit_rd_from_rob;
  logic [4:0]  commit_Q_from_rob;
  logic [31:0] commit_V_from_rob;
  logic        rollback_req_from_rob;
  logic        rollback_done_to_rob;
  logic        commit_flag_to_regfile;
  logic        rollback_flag_to_regfile;
  logic [4:0]  rd_to_regfile;
  logic [4:0]  Q_to_regfile;
  logic [31:0] V_to_regfile;
  logic [2:0]  pending_cnt;

  int checks   = 0;
  int failures = 0;
  bit monitorOn = 1'b0;

  rf_commit_sequencer #(
    .DEPTH(4), .DEPTH_LOG(2), .TAG_W(5), .RECOVER_CYCLES(2)
  ) dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .rdy_in                   (rdy_in),
    .commit_valid_from_rob    (commit_valid_from_rob),
    .commit_ready_to_rob      (commit_ready_to_rob),
    .commit_rd_from_rob       (commit_rd_from_rob),
    .commit_Q_from_rob        (commit_Q_from_rob),
    .commit_V_from_rob        (commit_V_from_rob),
    .rollback_req_from_rob    (rollback_req_from_rob),
    .rollback_done_to_rob     (rollback_done_to_rob),
    .commit_flag_to_regfile   (commit_flag_to_regfile),
    .rollback_flag_to_regfile (rollback_flag_to_regfile),
    .rd_to_regfile            (rd_to_regfile),
    .Q_to_regfile             (Q_to_regfile),
    .V_to_regfile             (V_to_regfile),
    .pending_cnt              (pending_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          rdy;
    bit          valid;
    logic [4:0]  rd;
    logic [4:0]  q;
    logic [31:0] v;
    bit          rb;
    bit          eCf;
    bit          eRf;
    bit          eDone;
    bit          eReady;
    logic [2:0]  eCnt;
    bit          chkData;
    logic [4:0]  eRd;
    logic [4:0]  eQ;
    logic [31:0] eV;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rdy, int valid, int rd, int q, int v, int rb,
                              int eCf, int eRf, int eDone, int eReady, int eCnt,
                              int chkData, int eRd, int eQ, int eV);
    vec_t r;
    r.rdy = 1'(rdy);   r.valid = 1'(valid); r.rd = 5'(rd); r.q = 5'(q);
    r.v = 32'(v);      r.rb = 1'(rb);       r.eCf = 1'(eCf); r.eRf = 1'(eRf);
    r.eDone = 1'(eDone); r.eReady = 1'(eReady); r.eCnt = 3'(eCnt);
    r.chkData = 1'(chkData); r.eRd = 5'(eRd); r.eQ = 5'(eQ); r.eV = 32'(eV);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rdy_in                = v.rdy;
    commit_valid_from_rob = v.valid;
    commit_rd_from_rob    = v.rd;
    commit_Q_from_rob     = v.q;
    commit_V_from_rob     = v.v;
    rollback_req_from_rob = v.rb;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idleInputs();
    rdy_in = 1'b1; commit_valid_from_rob = 1'b0; rollback_req_from_rob = 1'b0;
    commit_rd_from_rob = '0; commit_Q_from_rob = '0; commit_V_from_rob = '0;
  endtask

  // The two regfile strobes must never overlap.
  always @(negedge clk_in) begin
    if (monitorOn) begin
      checks++;
      if (commit_flag_to_regfile && rollback_flag_to_regfile) begin
        failures++;
        $display("[TB] FAIL strobe_exclusive: got both high expected at most one");
      end
    end
  end

  initial begin
    // Single commit, latency 2
    vecs.push_back(mk(1,1,5,3,32'hDEADBEEF,0, 0,0,0,1,1, 0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,0,0,1,0, 1,5,3,32'hDEADBEEF));
    vecs.push_back(mk(1,0,0,0,0,0,            0,0,0,1,0, 1,5,3,32'hDEADBEEF));
    // Six back-to-back commits rd=1..6
    for (int i = 1; i <= 6; i++)
      vecs.push_back(mk(1,1,i,i,i*256,0, (i>1)?1:0,0,0,1,1, (i>1)?1:0,i-1,i-1,(i-1)*256));
    vecs.push_back(mk(1,0,0,0,0,0, 1,0,0,1,0, 1,6,6,32'h600));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,1,0, 1,6,6,32'h600));
    // rd=0 commit is consumed without a strobe
    vecs.push_back(mk(1,1,0,2,32'h1234,0, 0,0,0,1,1, 0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,        0,0,0,1,0, 1,6,6,32'h600));
    vecs.push_back(mk(1,0,0,0,0,0,        0,0,0,1,0, 1,6,6,32'h600));
    // Rollback requested alongside the third commit
    vecs.push_back(mk(1,1,7,7,32'h700,0,  0,0,0,1,1, 0,0,0,0));
    vecs.push_back(mk(1,1,8,8,32'h800,0,  1,0,0,1,1, 1,7,7,32'h700));
    vecs.push_back(mk(1,1,9,9,32'h900,1,  1,0,0,0,1, 1,8,8,32'h800));
    vecs.push_back(mk(1,1,10,10,32'hA00,1, 1,0,0,0,0, 1,9,9,32'h900));
    vecs.push_back(mk(1,1,10,10,32'hA00,0, 0,1,0,0,0, 1,9,9,32'h900));
    vecs.push_back(mk(1,1,10,10,32'hA00,0, 0,0,0,0,0, 1,9,9,32'h900));
    vecs.push_back(mk(1,1,10,10,32'hA00,0, 0,0,0,0,0, 1,9,9,32'h900));
    vecs.push_back(mk(1,1,10,10,32'hA00,0, 0,0,1,1,0, 1,9,9,32'h900));
    vecs.push_back(mk(1,0,0,0,0,0,         0,0,0,1,0, 1,9,9,32'h900));
    // Freeze for 4 cycles mid-drain, then again during FLUSH
    vecs.push_back(mk(1,1,11,11,32'hB00,0, 0,0,0,1,1, 0,0,0,0));
    vecs.push_back(mk(1,1,12,12,32'hC00,1, 1,0,0,0,1, 1,11,11,32'hB00));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,13,13,32'hD00,1, 1,0,0,0,1, 1,11,11,32'hB00));
    vecs.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0, 1,12,12,32'hC00));
    vecs.push_back(mk(1,0,0,0,0,0, 0,1,0,0,0, 1,12,12,32'hC00));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0, 1,12,12,32'hC00));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 1,12,12,32'hC00));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 1,12,12,32'hC00));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,1,0, 1,12,12,32'hC00));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,1,0, 1,12,12,32'hC00));

    rst_in = 1'b1;
    idleInputs();
    tick();
    tick();
    checkOutput("reset_commit_flag", 32'(commit_flag_to_regfile), 32'd0);
    checkOutput("reset_rollback_flag", 32'(rollback_flag_to_regfile), 32'd0);
    checkOutput("reset_done", 32'(rollback_done_to_rob), 32'd0);
    checkOutput("reset_rd", 32'(rd_to_regfile), 32'd0);
    checkOutput("reset_V", V_to_regfile, 32'd0);
    checkOutput("reset_cnt", 32'(pending_cnt), 32'd0);
    rst_in = 1'b0;
    monitorOn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d_commit_flag", i), 32'(commit_flag_to_regfile), 32'(vecs[i].eCf));
      checkOutput($sformatf("v%0d_rollback_flag", i), 32'(rollback_flag_to_regfile), 32'(vecs[i].eRf));
      checkOutput($sformatf("v%0d_done", i), 32'(rollback_done_to_rob), 32'(vecs[i].eDone));
      checkOutput($sformatf("v%0d_ready", i), 32'(commit_ready_to_rob), 32'(vecs[i].eReady));
      checkOutput($sformatf("v%0d_cnt", i), 32'(pending_cnt), 32'(vecs[i].eCnt));
      if (vecs[i].chkData) begin
        checkOutput($sformatf("v%0d_rd", i), 32'(rd_to_regfile), 32'(vecs[i].eRd));
        checkOutput($sformatf("v%0d_Q", i), 32'(Q_to_regfile), 32'(vecs[i].eQ));
        checkOutput($sformatf("v%0d_V", i), V_to_regfile, vecs[i].eV);
      end
    end

    // Asynchronous reset while in RECOVER
    idleInputs();
    rollback_req_from_rob = 1'b1;
    tick();
    rollback_req_from_rob = 1'b0;
    tick();
    checkOutput("mid_flush_strobe", 32'(rollback_flag_to_regfile), 32'd1);
    tick();
    checkOutput("mid_recover_ready", 32'(commit_ready_to_rob), 32'd0);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("async_rst_rollback_flag", 32'(rollback_flag_to_regfile), 32'd0);
    checkOutput("async_rst_done", 32'(rollback_done_to_rob), 32'd0);
    checkOutput("async_rst_rd", 32'(rd_to_regfile), 32'd0);
    checkOutput("async_rst_Q", 32'(Q_to_regfile), 32'd0);
    checkOutput("async_rst_V", V_to_regfile, 32'd0);
    checkOutput("async_rst_cnt", 32'(pending_cnt), 32'd0);
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("post_rst_no_done_%0d", i), 32'(rollback_done_to_rob), 32'd0);
      checkOutput($sformatf("post_rst_ready_%0d", i), 32'(commit_ready_to_rob), 32'd1);
    end

    // Normal operation resumes after reset
    commit_valid_from_rob = 1'b1;
    commit_rd_from_rob = 5'd5; commit_Q_from_rob = 5'd3; commit_V_from_rob = 32'hDEADBEEF;
    tick();
    commit_valid_from_rob = 1'b0;
    checkOutput("post_rst_accept_cnt", 32'(pending_cnt), 32'd1);
    tick();
    checkOutput("post_rst_commit_flag", 32'(commit_flag_to_regfile), 32'd1);
    checkOutput("post_rst_commit_rd", 32'(rd_to_regfile), 32'd5);
    checkOutput("post_rst_commit_V", V_to_regfile, 32'hDEADBEEF);
    tick();
    checkOutput("post_rst_flag_drop", 32'(commit_flag_to_regfile), 32'd0);

    monitorOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
